// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter for the RAM/LEDS bus (optional MEM_BUS_ERR_EN)
module mem_bus_arbiter #(
    parameter int DW     = 9,
    parameter int AW     = 9,
    parameter int RAM_AW = 7
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_req,
    input  logic [AW-1:0]     m0_addr,
    input  logic              m0_we,
    input  logic [DW-1:0]     m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DW-1:0]     m0_rdata,
    input  logic              m1_req,
    input  logic [AW-1:0]     m1_addr,
    input  logic              m1_we,
    input  logic [DW-1:0]     m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DW-1:0]     m1_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_wdata,
    output logic              ram_wren,
    input  logic [DW-1:0]     ram_q,
    output logic              leds_wr,
    output logic [DW-1:0]     leds_data,
    output logic              busy
`ifdef MEM_BUS_ERR_EN
    ,
    output logic              bus_err,
    output logic [AW-1:0]     bus_err_addr
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

    localparam logic [1:0] REG_RAM  = 2'b00;
    localparam logic [1:0] REG_LEDS = 2'b01;

    state_t          state;
    logic            last;
    logic            win;
    logic [AW-1:0]   addr_q;
    logic            we_q;

    logic            pick_v;
    logic            pick;
    logic [AW-1:0]   sel_addr;
    logic            sel_we;
    logic [DW-1:0]   sel_wdata;
    logic [1:0]      sel_region;
    logic [DW-1:0]   rd_mux;

    // Contention goes to whoever did not win last; a lone requester always wins.
    assign pick_v     = m0_req | m1_req;
    assign pick       = (m0_req & m1_req) ? ~last : m1_req;
    assign sel_addr   = pick ? m1_addr  : m0_addr;
    assign sel_we     = pick ? m1_we    : m0_we;
    assign sel_wdata  = pick ? m1_wdata : m0_wdata;
    assign sel_region = sel_addr[AW-1:AW-2];

    assign busy = (state != IDLE);

    // RAM data arrives during RDWAIT, so read data is steered combinationally.
    assign rd_mux   = (state == RDWAIT && addr_q[AW-1:AW-2] == REG_RAM) ? ram_q : '0;
    assign m0_rdata = (state == RDWAIT && !win) ? rd_mux : '0;
    assign m1_rdata = (state == RDWAIT &&  win) ? rd_mux : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            last      <= 1'b1;
            win       <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wren  <= 1'b0;
            leds_wr   <= 1'b0;
            leds_data <= '0;
`ifdef MEM_BUS_ERR_EN
            bus_err      <= 1'b0;
            bus_err_addr <= '0;
`endif
        end else begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            ram_wren  <= 1'b0;
            leds_wr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_v) begin
                        state  <= ACCESS;
                        win    <= pick;
                        last   <= pick;
                        addr_q <= sel_addr;
                        we_q   <= sel_we;
                        m0_gnt <= ~pick;
                        m1_gnt <= pick;
                        if (sel_region == REG_RAM) begin
                            ram_addr  <= sel_addr[RAM_AW-1:0];
                            ram_wdata <= sel_wdata;
                            ram_wren  <= sel_we;
                        end else if (sel_region == REG_LEDS && sel_we) begin
                            leds_wr   <= 1'b1;
                            leds_data <= sel_wdata;
                        end
`ifdef MEM_BUS_ERR_EN
                        if (!bus_err && (sel_region[1] || (sel_region == REG_LEDS && !sel_we))) begin
                            bus_err      <= 1'b1;
                            bus_err_addr <= sel_addr;
                        end
`endif
                    end
                end
                ACCESS: begin
                    state     <= we_q ? IDLE : RDWAIT;
                    m0_rvalid <= ~we_q & ~win;
                    m1_rvalid <= ~we_q &  win;
                end
                RDWAIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       m0_req = 1'b0, m1_req = 1'b0;
    logic [8:0] m0_addr = '0, m1_addr = '0;
    logic       m0_we = 1'b0, m1_we = 1'b0;
    logic [8:0] m0_wdata = '0, m1_wdata = '0;
    logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [8:0] m0_rdata, m1_rdata;
    logic [6:0] ram_addr;
    logic [8:0] ram_wdata;
    logic       ram_wren;
    logic [8:0] ram_q = '0;
    logic       leds_wr;
    logic [8:0] leds_data;
    logic       busy;
`ifdef MEM_BUS_ERR_EN
    logic       bus_err;
    logic [8:0] bus_err_addr;
`endif

    int compared = 0;
    int mismatched = 0;
    logic [8:0] mem [128];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    mem_bus_arbiter dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q),
        .leds_wr(leds_wr), .leds_data(leds_data), .busy(busy)
`ifdef MEM_BUS_ERR_EN
        , .bus_err(bus_err), .bus_err_addr(bus_err_addr)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy got %0h want 0", busy); end
        compared++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0) begin mismatched++; $display("FAIL rst_pulses got %b want 0000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}); end
        compared++; if ({ram_wren, leds_wr} !== 2'b0) begin mismatched++; $display("FAIL rst_strobes got %b want 00", {ram_wren, leds_wr}); end
        compared++; if ({ram_addr, ram_wdata, leds_data, m0_rdata, m1_rdata} !== '0) begin mismatched++; $display("FAIL rst_data got %h want 0", {ram_addr, ram_wdata, leds_data, m0_rdata, m1_rdata}); end
`ifdef MEM_BUS_ERR_EN
        compared++; if ({bus_err, bus_err_addr} !== 10'h0) begin mismatched++; $display("FAIL rst_err got %h want 0", {bus_err, bus_err_addr}); end
`endif
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_ram_write();
        m0_req = 1'b1; m0_addr = 9'h005; m0_we = 1'b1; m0_wdata = 9'h1A3;
        tick();
        compared++; if ({m0_gnt, m1_gnt} !== 2'b10) begin mismatched++; $display("FAIL wr_gnt got %b want 10", {m0_gnt, m1_gnt}); end
        compared++; if (ram_wren !== 1'b1) begin mismatched++; $display("FAIL wr_wren got %0h want 1", ram_wren); end
        compared++; if (ram_addr !== 7'h05) begin mismatched++; $display("FAIL wr_addr got %0h want 05", ram_addr); end
        compared++; if (ram_wdata !== 9'h1A3) begin mismatched++; $display("FAIL wr_wdata got %0h want 1a3", ram_wdata); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL wr_busy got %0h want 1", busy); end
        m0_req = 1'b0;
        tick();
        compared++; if ({busy, m0_gnt, ram_wren, m0_rvalid} !== 4'b0) begin mismatched++; $display("FAIL wr_done got %b want 0000", {busy, m0_gnt, ram_wren, m0_rvalid}); end
    endtask

    task automatic test_ram_read();
        m0_req = 1'b1; m0_addr = 9'h005; m0_we = 1'b0;
        tick();
        compared++; if ({m0_gnt, ram_wren, m0_rvalid} !== 3'b100) begin mismatched++; $display("FAIL rd_gnt got %b want 100", {m0_gnt, ram_wren, m0_rvalid}); end
        m0_req = 1'b0;
        tick();
        compared++; if (m0_rvalid !== 1'b1) begin mismatched++; $display("FAIL rd_rvalid got %0h want 1", m0_rvalid); end
        compared++; if (m0_rdata !== 9'h1A3) begin mismatched++; $display("FAIL rd_rdata got %0h want 1a3", m0_rdata); end
        compared++; if ({m1_gnt, m1_rvalid, m1_rdata} !== 11'h0) begin mismatched++; $display("FAIL rd_m1_quiet got %h want 0", {m1_gnt, m1_rvalid, m1_rdata}); end
        tick();
        compared++; if ({busy, m0_rvalid, m0_rdata} !== 11'h0) begin mismatched++; $display("FAIL rd_done got %h want 0", {busy, m0_rvalid, m0_rdata}); end
    endtask

    task automatic test_round_robin();
        logic [8:0] want;
        logic       exp_id;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        mem[7'h20] = 9'h0AA; mem[7'h21] = 9'h133;
        m0_addr = 9'h020; m0_we = 1'b0; m1_addr = 9'h021; m1_we = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_id = t[0];
            want = exp_id ? 9'h133 : 9'h0AA;
            tick();
            compared++; if ({m1_gnt, m0_gnt} !== (exp_id ? 2'b10 : 2'b01)) begin mismatched++; $display("FAIL rr_gnt%0d got %b want id %0d", t, {m1_gnt, m0_gnt}, exp_id); end
            tick();
            compared++; if ({m1_rvalid, m0_rvalid} !== (exp_id ? 2'b10 : 2'b01)) begin mismatched++; $display("FAIL rr_rvalid%0d got %b want id %0d", t, {m1_rvalid, m0_rvalid}, exp_id); end
            compared++; if ((exp_id ? m1_rdata : m0_rdata) !== want) begin mismatched++; $display("FAIL rr_rdata%0d got %0h want %0h", t, exp_id ? m1_rdata : m0_rdata, want); end
            compared++; if ((exp_id ? m0_rdata : m1_rdata) !== 9'h0) begin mismatched++; $display("FAIL rr_other%0d got %0h want 0", t, exp_id ? m0_rdata : m1_rdata); end
            if (t == 3) begin m0_req = 1'b0; m1_req = 1'b0; end
            tick();
        end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rr_idle got %0h want 0", busy); end
    endtask

    task automatic test_leds();
        m1_req = 1'b1; m1_addr = 9'h080; m1_we = 1'b1; m1_wdata = 9'h155;
        tick();
        compared++; if ({m1_gnt, m0_gnt} !== 2'b10) begin mismatched++; $display("FAIL led_gnt got %b want 10", {m1_gnt, m0_gnt}); end
        compared++; if ({leds_wr, ram_wren} !== 2'b10) begin mismatched++; $display("FAIL led_strobes got %b want 10", {leds_wr, ram_wren}); end
        compared++; if (leds_data !== 9'h155) begin mismatched++; $display("FAIL led_data got %0h want 155", leds_data); end
        m1_req = 1'b0;
        tick();
        compared++; if ({busy, leds_wr} !== 2'b00) begin mismatched++; $display("FAIL led_done got %b want 00", {busy, leds_wr}); end
    endtask

    task automatic test_unmapped();
        m0_req = 1'b1; m0_addr = 9'h100; m0_we = 1'b0;
        tick();
        compared++; if ({m0_gnt, ram_wren, leds_wr} !== 3'b100) begin mismatched++; $display("FAIL um_access got %b want 100", {m0_gnt, ram_wren, leds_wr}); end
        m0_req = 1'b0;
        tick();
        compared++; if (m0_rvalid !== 1'b1) begin mismatched++; $display("FAIL um_rvalid got %0h want 1", m0_rvalid); end
        compared++; if (m0_rdata !== 9'h0) begin mismatched++; $display("FAIL um_rdata got %0h want 0", m0_rdata); end
        tick();
`ifdef MEM_BUS_ERR_EN
        compared++; if ({bus_err, bus_err_addr} !== {1'b1, 9'h100}) begin mismatched++; $display("FAIL err_first got %h want 100 with flag", {bus_err, bus_err_addr}); end
`endif
        m0_req = 1'b1; m0_addr = 9'h180; m0_we = 1'b1; m0_wdata = 9'h011;
        tick();
        compared++; if ({m0_gnt, ram_wren, leds_wr} !== 3'b100) begin mismatched++; $display("FAIL um_wr got %b want 100", {m0_gnt, ram_wren, leds_wr}); end
        m0_req = 1'b0;
        tick();
        compared++; if ({busy, m0_rvalid} !== 2'b00) begin mismatched++; $display("FAIL um_wr_done got %b want 00", {busy, m0_rvalid}); end
`ifdef MEM_BUS_ERR_EN
        compared++; if ({bus_err, bus_err_addr} !== {1'b1, 9'h100}) begin mismatched++; $display("FAIL err_sticky got %h want 100 with flag", {bus_err, bus_err_addr}); end
`endif
    endtask

    task automatic test_reset_abort();
        mem[7'h07] = 9'h000;
        m0_req = 1'b1; m0_addr = 9'h007; m0_we = 1'b1; m0_wdata = 9'h0FF;
        tick();
        compared++; if ({m0_gnt, ram_wren} !== 2'b11) begin mismatched++; $display("FAIL ab_access got %b want 11", {m0_gnt, ram_wren}); end
        #2 resetn = 1'b0;
        #1;
        compared++; if ({m0_gnt, ram_wren, busy} !== 3'b000) begin mismatched++; $display("FAIL ab_async got %b want 000", {m0_gnt, ram_wren, busy}); end
        tick();
        compared++; if (mem[7'h07] !== 9'h000) begin mismatched++; $display("FAIL ab_nowrite got %0h want 0", mem[7'h07]); end
        resetn = 1'b1;
        compared++; if ({busy, m0_gnt, m0_rvalid} !== 3'b000) begin mismatched++; $display("FAIL ab_idle got %b want 000", {busy, m0_gnt, m0_rvalid}); end
        tick();
        compared++; if ({m0_gnt, ram_wren, ram_addr} !== {2'b11, 7'h07}) begin mismatched++; $display("FAIL ab_regrant got %h want 187", {m0_gnt, ram_wren, ram_addr}); end
        m0_req = 1'b0;
        tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL ab_done got %0h want 0", busy); end
`ifdef MEM_BUS_ERR_EN
        compared++; if (bus_err !== 1'b0) begin mismatched++; $display("FAIL ab_err_clr got %0h want 0", bus_err); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 9'(i * 3 + 1);
        #2;
        test_reset();
        test_ram_write();
        test_ram_read();
        test_round_robin();
        test_leds();
        test_unmapped();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
